// File: rtl/spi_pkg.sv
// Purpose : shared SPI transmit types and default constants.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: spi_state_t (IDLE, SHIFT), SPI_W_DEF, SPI_IDLE_LEVEL_DEF.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int   SPI_W_DEF          = 8;
    localparam logic SPI_IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/spi_tx_shifter.sv
// Purpose : parallel-to-serial SPI transmit shifter, one bit per shift_en strobe.
// Latency : first bit on SO one clk after the tx_valid/tx_ready transfer.
// Backpressure: tx_ready low while a word is shifting (or, with SPI_TX_DBUF_EN,
//               while the one-entry holding register is occupied).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (dominates everything)
//   shift_en       one-cycle strobe per SCK shifting edge
//   abort          frame abort; returns to IDLE next cycle, drops any words
//   tx_valid/tx_ready/tx_data   producer handshake, W-bit word
//   SO             registered serial output, IDLE_LEVEL when not shifting
//   busy           high while in SHIFT
//   frame_done     one-cycle pulse when the last word of a frame completes
//   underrun       one-cycle pulse when shift_en arrives in IDLE
//
// Optional feature: define SPI_TX_DBUF_EN to add a one-entry holding register
// so words can be queued while shifting and sent back-to-back.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int   W          = SPI_W_DEF,
    parameter int   LSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = SPI_IDLE_LEVEL_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         abort,
    input  logic         tx_valid,
    input  logic [W-1:0] tx_data,
    output logic         tx_ready,
    output logic         SO,
    output logic         busy,
    output logic         frame_done,
    output logic         underrun
);

    localparam int             CW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_BIT  = CW'(W - 1);
    localparam logic [W-1:0]   IDLE_FILL = {W{IDLE_LEVEL}};

    spi_state_t     state, state_d;
    logic [W-1:0]   sreg, sreg_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           so_q, so_d;
    logic           fd_q, fd_d;
    logic           ur_q, ur_d;
    logic           xfer;
    logic           last_edge;
    logic [W-1:0]   sreg_sh;

`ifdef SPI_TX_DBUF_EN
    logic           pend, pend_d;
    logic [W-1:0]   hold, hold_d;
`endif

    // Bit that goes on the wire first for a freshly loaded word.
    function automatic logic first_bit(input logic [W-1:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[W-1];
    endfunction

    // Shift register advances one bit; the vacated end fills with IDLE_LEVEL.
    function automatic logic [W-1:0] shift_once(input logic [W-1:0] d);
        return (LSB_FIRST != 0) ? {IDLE_LEVEL, d[W-1:1]} : {d[W-2:0], IDLE_LEVEL};
    endfunction

`ifdef SPI_TX_DBUF_EN
    assign tx_ready = !pend;
`else
    assign tx_ready = (state == IDLE) && !rst;
`endif

    assign xfer      = tx_valid && tx_ready;
    assign last_edge = shift_en && (cnt == LAST_BIT);
    assign sreg_sh   = shift_once(sreg);

    assign SO         = so_q;
    assign busy       = (state == SHIFT);
    assign frame_done = fd_q;
    assign underrun   = ur_q;

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        so_d    = so_q;
        fd_d    = 1'b0;
        ur_d    = 1'b0;
`ifdef SPI_TX_DBUF_EN
        pend_d  = pend;
        hold_d  = hold;
`endif
        if (abort) begin
            // Abort beats both shift_en and any transfer in the same cycle.
            state_d = IDLE;
            sreg_d  = IDLE_FILL;
            cnt_d   = '0;
            so_d    = IDLE_LEVEL;
`ifdef SPI_TX_DBUF_EN
            pend_d  = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ur_d = shift_en;
                    if (xfer) begin
                        state_d = SHIFT;
                        sreg_d  = tx_data;
                        so_d    = first_bit(tx_data);
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (last_edge) begin
`ifdef SPI_TX_DBUF_EN
                        if (pend) begin
                            // Queued word follows with no idle bit in between.
                            sreg_d = hold;
                            so_d   = first_bit(hold);
                            cnt_d  = '0;
                            pend_d = 1'b0;
                        end else if (xfer) begin
                            // Word arriving exactly at the last edge bypasses the holding register.
                            sreg_d = tx_data;
                            so_d   = first_bit(tx_data);
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                            sreg_d  = IDLE_FILL;
                            so_d    = IDLE_LEVEL;
                            cnt_d   = '0;
                            fd_d    = 1'b1;
                        end
`else
                        state_d = IDLE;
                        sreg_d  = IDLE_FILL;
                        so_d    = IDLE_LEVEL;
                        cnt_d   = '0;
                        fd_d    = 1'b1;
`endif
                    end else if (shift_en) begin
                        sreg_d = sreg_sh;
                        so_d   = first_bit(sreg_sh);
                        cnt_d  = cnt + CW'(1);
                    end
`ifdef SPI_TX_DBUF_EN
                    if (xfer && !last_edge) begin
                        pend_d = 1'b1;
                        hold_d = tx_data;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= IDLE_FILL;
            cnt   <= '0;
            so_q  <= IDLE_LEVEL;
            fd_q  <= 1'b0;
            ur_q  <= 1'b0;
`ifdef SPI_TX_DBUF_EN
            pend  <= 1'b0;
            hold  <= '0;
`endif
        end else begin
            state <= state_d;
            sreg  <= sreg_d;
            cnt   <= cnt_d;
            so_q  <= so_d;
            fd_q  <= fd_d;
            ur_q  <= ur_d;
`ifdef SPI_TX_DBUF_EN
            pend  <= pend_d;
            hold  <= hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Purpose : self-checking bench for spi_tx_shifter; three instances
//           (W=8 MSB-first idle 0, W=8 LSB-first idle 1, W=16 MSB-first idle 0)
//           share one stimulus stream and are each tracked by a bit-position model.
// Ports   : drives clk, rst, shift_en, abort, tx_valid, tx_data; observes all outputs.
module tb_spi_tx_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        shift_en = 1'b0;
    logic        abort = 1'b0;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = 16'h0;

    logic [2:0] rdy_o, so_o, busy_o, fd_o, ur_o;

    always #5 clk = ~clk;

`ifdef SPI_TX_DBUF_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    spi_tx_shifter #(.W(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .abort(abort),
        .tx_valid(tx_valid), .tx_data(tx_data[7:0]), .tx_ready(rdy_o[0]),
        .SO(so_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]), .underrun(ur_o[0]));

    spi_tx_shifter #(.W(8), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .abort(abort),
        .tx_valid(tx_valid), .tx_data(tx_data[7:0]), .tx_ready(rdy_o[1]),
        .SO(so_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]), .underrun(ur_o[1]));

    spi_tx_shifter #(.W(16), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) u2 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .abort(abort),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(rdy_o[2]),
        .SO(so_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]), .underrun(ur_o[2]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: each instance holds a word and a count of bits already sent.
    int          mw    [3] = '{8, 8, 16};
    bit          mlsb  [3] = '{1'b0, 1'b1, 1'b0};
    bit          midle [3] = '{1'b0, 1'b1, 1'b0};
    bit          m_busy[3];
    int          m_pos [3];
    logic [15:0] m_word[3];
    bit          m_pend[3];
    logic [15:0] m_pword[3];
    bit          m_fd  [3];
    bit          m_ur  [3];
    bit          model_on = 1'b0;
    int          fd_seen[3];

    function automatic bit model_rdy(int d);
        return DB ? !m_pend[d] : (!m_busy[d] && !rst);
    endfunction

    function automatic logic [4:0] exp_out(int d);
        logic so;
        int   idx;
        idx = mlsb[d] ? m_pos[d] : (mw[d] - 1 - m_pos[d]);
        so  = m_busy[d] ? m_word[d][idx] : midle[d];
        return {so, m_busy[d], m_fd[d], m_ur[d], model_rdy(d)};
    endfunction

    function automatic void model_step(int d);
        logic [15:0] dat;
        bit xfer, took, was_busy;
        dat = (mw[d] == 16) ? tx_data : {8'h00, tx_data[7:0]};
        if (rst || abort) begin
            m_busy[d] = 0; m_pos[d] = 0; m_pend[d] = 0; m_fd[d] = 0; m_ur[d] = 0;
            return;
        end
        xfer     = tx_valid && model_rdy(d);
        was_busy = m_busy[d];
        took     = 0;
        m_fd[d]  = 0;
        m_ur[d]  = shift_en && !was_busy;
        if (was_busy && shift_en) begin
            m_pos[d]++;
            if (m_pos[d] == mw[d]) begin
                m_pos[d] = 0;
                if (m_pend[d]) begin
                    m_word[d] = m_pword[d];
                    m_pend[d] = 0;
                end else if (DB && xfer) begin
                    m_word[d] = dat;
                    took = 1;
                end else begin
                    m_busy[d] = 0;
                    m_fd[d]   = 1;
                end
            end
        end
        if (xfer && !took) begin
            if (!was_busy) begin
                m_busy[d] = 1; m_word[d] = dat; m_pos[d] = 0;
            end else begin
                m_pend[d] = 1; m_pword[d] = dat;
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) model_step(d);
    end

    // One clock: inputs are applied by the caller, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            fd_seen[d] += int'(fd_o[d]);
            if (model_on)
                chk($sformatf("model_dut%0d", d),
                    {11'b0, so_o[d], busy_o[d], fd_o[d], ur_o[d], rdy_o[d]},
                    {11'b0, exp_out(d)});
        end
    endtask

    typedef struct {
        logic        rst, se, vld, ab;
        logic [15:0] dat;
        logic        so, busy, fd, ur;
    } vec_t;

    vec_t tv[23];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp8;
        logic [15:0] got;

        // Directed vectors on the W=8 MSB-first instance (u0): rst, sei, vld, abort, data -> SO, busy, frame_done, underrun
        tv[0]  = '{1,0,0,0,16'h0000, 0,0,0,0};
        tv[1]  = '{0,1,0,0,16'h0000, 0,0,0,1};
        tv[2]  = '{0,0,0,0,16'h0000, 0,0,0,0};
        tv[3]  = '{0,0,1,0,16'h00A5, 1,1,0,0};
        tv[4]  = '{0,0,0,0,16'h0000, 1,1,0,0};
        tv[5]  = '{0,1,0,0,16'h0000, 0,1,0,0};
        tv[6]  = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[7]  = '{0,1,0,0,16'h0000, 0,1,0,0};
        tv[8]  = '{0,1,0,0,16'h0000, 0,1,0,0};
        tv[9]  = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[10] = '{0,1,0,0,16'h0000, 0,1,0,0};
        tv[11] = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[12] = '{0,1,0,0,16'h0000, 0,0,1,0};
        tv[13] = '{0,0,0,0,16'h0000, 0,0,0,0};
        tv[14] = '{0,0,1,0,16'h00FF, 1,1,0,0};
        tv[15] = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[16] = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[17] = '{0,1,1,1,16'h00FF, 0,0,0,0};
        tv[18] = '{0,0,0,0,16'h0000, 0,0,0,0};
        tv[19] = '{0,0,1,0,16'h00FF, 1,1,0,0};
        tv[20] = '{0,1,0,0,16'h0000, 1,1,0,0};
        tv[21] = '{1,1,0,0,16'h0000, 0,0,0,0};
        tv[22] = '{0,0,0,0,16'h0000, 0,0,0,0};

        model_on = 1'b1;
        for (int i = 0; i < 23; i++) begin
            rst = tv[i].rst; shift_en = tv[i].se; tx_valid = tv[i].vld;
            abort = tv[i].ab; tx_data = tv[i].dat;
            tick();
            chk($sformatf("vec%0d", i), {12'b0, so_o[0], busy_o[0], fd_o[0], ur_o[0]},
                {12'b0, tv[i].so, tv[i].busy, tv[i].fd, tv[i].ur});
        end
        rst = 0; shift_en = 0; tx_valid = 0; abort = 0;

        // 8'hA5 with shift_en spaced 3 clk: MSB order on u0, LSB order on u1.
        exp8 = 8'hA5;
        for (int d = 0; d < 3; d++) fd_seen[d] = 0;
        tx_valid = 1; tx_data = 16'h00A5; tick(); tx_valid = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_msb_bit%0d", i), so_o[0], exp8[7-i]);
            chk($sformatf("a5_lsb_bit%0d", i), so_o[1], exp8[i]);
            tick(); tick();
            shift_en = 1; tick(); shift_en = 0;
        end
        chk("a5_frame_done_count", fd_seen[0], 1);
        chk("a5_busy_after", busy_o[0], 0);
        chk("a5_so_idle", so_o[0], 0);

        // 8'h01: LSB-first shows 1 then seven 0s, then its idle level (1).
        exp8 = 8'h01;
        tx_valid = 1; tx_data = 16'h0001; tick(); tx_valid = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("x01_lsb_bit%0d", i), so_o[1], exp8[i]);
            shift_en = 1; tick(); shift_en = 0;
        end
        chk("x01_lsb_idle_level", so_o[1], 1);
        chk("x01_lsb_busy_after", busy_o[1], 0);

`ifndef SPI_TX_DBUF_EN
        // W=16: tx_valid held through the word, accepted on the first IDLE cycle.
        rst = 1; tick(); rst = 0; tick();
        tx_valid = 1; tx_data = 16'hC3A5; tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("w16_rdy_low%0d", i), rdy_o[2], 0);
            shift_en = 1; tick(); shift_en = 0;
        end
        chk("w16_frame_done", fd_o[2], 1);
        chk("w16_rdy_idle", rdy_o[2], 1);
        tick();
        chk("w16_reaccepted_busy", busy_o[2], 1);
        chk("w16_reaccepted_so", so_o[2], 1);
        tx_valid = 0;
`else
        // Back-to-back F0 then 0F through the holding register.
        rst = 1; tick(); rst = 0; tick();
        for (int d = 0; d < 3; d++) fd_seen[d] = 0;
        tx_valid = 1; tx_data = 16'h00F0; tick();
        tx_data = 16'h000F; tick(); tx_valid = 0;
        chk("dbuf_rdy_low_pending", rdy_o[0], 0);
        got = 16'h0;
        for (int i = 0; i < 16; i++) begin
            got[15-i] = so_o[0];
            shift_en = 1; tick(); shift_en = 0;
        end
        chk("dbuf_bits", got, 16'hF00F);
        chk("dbuf_frame_done_count", fd_seen[0], 1);
        chk("dbuf_frame_done_last", fd_o[0], 1);
        chk("dbuf_busy_after", busy_o[0], 0);

        // Abort after 3 bits with a word pending.
        for (int d = 0; d < 3; d++) fd_seen[d] = 0;
        tx_valid = 1; tx_data = 16'h00FF; tick();
        tx_data = 16'h003C; tick(); tx_valid = 0;
        for (int i = 0; i < 3; i++) begin shift_en = 1; tick(); end
        shift_en = 0;
        abort = 1; tick(); abort = 0;
        chk("abort_busy", busy_o[0], 0);
        chk("abort_so", so_o[0], 0);
        chk("abort_pending_cleared", rdy_o[0], 1);
        chk("abort_no_frame_done", fd_seen[0], 0);
        tick();
        chk("abort_stays_idle", busy_o[0], 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            shift_en = ($urandom_range(0, 2) == 0);
            tx_valid = ($urandom_range(0, 1) == 0);
            tx_data  = 16'($urandom);
            tick();
        end
        rst = 0; abort = 0; shift_en = 0; tx_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
